// File: rtl/fpmul_pkg.sv
// fpmul_pkg: shared widths, constants and the stage-1 record for the fp16
// multiplier normalize/round stage.
//   EXP_W/MAN_W/BIAS : half-precision field widths and exponent bias
//   PROD_W           : width of the {1,fa}*{1,fb} significand product
//   RES_W            : width of a packed half-precision result
//   s1_t             : normalized operand set held between the two stages
package fpmul_pkg;

  localparam int EXP_W   = 5;
  localparam int MAN_W   = 10;
  localparam int BIAS    = 15;
  localparam int EXP_MAX = 31;
  localparam int PROD_W  = 2 * MAN_W + 2;
  localparam int RES_W   = 1 + EXP_W + MAN_W;

  localparam logic [EXP_W-1:0]       EXP_INF  = '1;
  localparam logic [MAN_W-1:0]       MAN_ZERO = '0;
  localparam logic [EXP_W+MAN_W-1:0] MAG_ZERO = '0;

  // e1 is the unbiased exponent after normalization; 8 bits signed covers
  // every reachable value (-15..48) plus the rounding carry.
  typedef struct packed {
    logic              sign;
    logic              zero;
    logic signed [7:0] e1;
    logic [MAN_W-1:0]  mant;
    logic              guard;
    logic              sticky;
  } s1_t;

endpackage

// File: rtl/fpmul_rne_round.sv
// fpmul_rne_round: combinational round-to-nearest-even plus exponent range
// check for one normalized significand.
//   mant_i/guard_i/sticky_i : truncated fraction and the two rounding bits
//   e1_i                    : unbiased exponent before rounding
//   m_o                     : rounded fraction
//   e2_o                    : exponent field after rounding (valid when in range)
//   ovf_o / unf_o           : rounded exponent at or above EXP_MAX / at or below 0
module fpmul_rne_round
  import fpmul_pkg::*;
(
  input  logic [MAN_W-1:0]  mant_i,
  input  logic              guard_i,
  input  logic              sticky_i,
  input  logic signed [7:0] e1_i,
  output logic [MAN_W-1:0]  m_o,
  output logic [EXP_W-1:0]  e2_o,
  output logic              ovf_o,
  output logic              unf_o
);

  logic              rup;
  logic [MAN_W:0]    sum;
  logic signed [7:0] e2;

  // A carry out of the fraction means the significand rolled over to 2.0;
  // the fraction is then all zeros and the exponent moves up by one.
  always_comb begin
    rup   = guard_i & (sticky_i | mant_i[0]);
    sum   = {1'b0, mant_i} + {{MAN_W{1'b0}}, rup};
    m_o   = sum[MAN_W] ? MAN_ZERO : sum[MAN_W-1:0];
    e2    = e1_i + $signed({7'd0, sum[MAN_W]});
    ovf_o = (int'(e2) >= EXP_MAX);
    unf_o = (int'(e2) <= 0);
    e2_o  = e2[EXP_W-1:0];
  end

endmodule

// File: rtl/fpmul_norm_round.sv
// fpmul_norm_round: two-stage normalize / round / range-check stage of the
// fp16 multiplier, with valid/ready handshakes on both sides.
//   clk, rst_n                 : clock, synchronous active-low reset
//   in_valid_i / in_ready_o    : upstream handshake
//   in_sign_i                  : result sign (sa ^ sb)
//   in_exp_sum_i               : raw biased exponent sum ea+eb (0..62)
//   in_prod_i                  : 22-bit product {1,fa}*{1,fb}
//   in_zero_i                  : either operand was zero
//   out_valid_o / out_ready_i  : downstream handshake
//   out_result_o               : packed half {sign, exp, frac}
//   out_ovf_o / out_unf_o      : result saturated to infinity / flushed to zero
module fpmul_norm_round
  import fpmul_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              in_sign_i,
  input  logic [EXP_W:0]    in_exp_sum_i,
  input  logic [PROD_W-1:0] in_prod_i,
  input  logic              in_zero_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [RES_W-1:0]  out_result_o,
  output logic              out_ovf_o,
  output logic              out_unf_o
);

  logic             s1_valid_q, s1_valid_d;
  s1_t              s1_q, s1_d, s1_new;
  logic             out_valid_q, out_valid_d;
  logic [RES_W-1:0] out_result_q, out_result_d;
  logic             out_ovf_q, out_ovf_d;
  logic             out_unf_q, out_unf_d;

  logic             norm;
  logic             s2_adv;
  logic             accept;
  logic [MAN_W-1:0] rnd_m;
  logic [EXP_W-1:0] rnd_e2;
  logic             rnd_ovf;
  logic             rnd_unf;

  assign s2_adv     = !out_valid_q || out_ready_i;
  assign in_ready_o = !s1_valid_q || s2_adv;
  assign accept     = in_valid_i && in_ready_o;

  // Stage 1: pick the fraction window by the product's leading bit and fold
  // everything below the guard bit into sticky.
  always_comb begin
    norm          = in_prod_i[PROD_W-1];
    s1_new.sign   = in_sign_i;
    s1_new.zero   = in_zero_i;
    s1_new.e1     = 8'(in_exp_sum_i) + 8'(norm) - 8'(BIAS);
    if (norm) begin
      s1_new.mant   = in_prod_i[PROD_W-2 -: MAN_W];
      s1_new.guard  = in_prod_i[MAN_W];
      s1_new.sticky = |in_prod_i[MAN_W-1:0];
    end else begin
      s1_new.mant   = in_prod_i[PROD_W-3 -: MAN_W];
      s1_new.guard  = in_prod_i[MAN_W-1];
      s1_new.sticky = |in_prod_i[MAN_W-2:0];
    end

    s1_d       = s1_q;
    s1_valid_d = s1_valid_q;
    if (accept) begin
      s1_d       = s1_new;
      s1_valid_d = 1'b1;
    end else if (s2_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  fpmul_rne_round u_round (
    .mant_i   (s1_q.mant),
    .guard_i  (s1_q.guard),
    .sticky_i (s1_q.sticky),
    .e1_i     (s1_q.e1),
    .m_o      (rnd_m),
    .e2_o     (rnd_e2),
    .ovf_o    (rnd_ovf),
    .unf_o    (rnd_unf)
  );

  // Stage 2: zero beats overflow beats underflow; the output register only
  // moves when downstream is not stalling it.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_ovf_d    = out_ovf_q;
    out_unf_d    = out_unf_q;
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_ovf_d = 1'b0;
        out_unf_d = 1'b0;
        if (s1_q.zero) begin
          out_result_d = {s1_q.sign, MAG_ZERO};
        end else if (rnd_ovf) begin
          out_result_d = {s1_q.sign, EXP_INF, MAN_ZERO};
          out_ovf_d    = 1'b1;
        end else if (rnd_unf) begin
          out_result_d = {s1_q.sign, MAG_ZERO};
          out_unf_d    = 1'b1;
        end else begin
          out_result_d = {s1_q.sign, rnd_e2, rnd_m};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_q         <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_ovf_q    <= 1'b0;
      out_unf_q    <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_q         <= s1_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_ovf_q    <= out_ovf_d;
      out_unf_q    <= out_unf_d;
    end
  end

  assign out_valid_o  = out_valid_q;
  assign out_result_o = out_result_q;
  assign out_ovf_o    = out_ovf_q;
  assign out_unf_o    = out_unf_q;

endmodule

// File: tb/tb_fpmul_norm_round.sv
// tb_fpmul_norm_round: directed and random stimulus for fpmul_norm_round with
// a reference-model scoreboard keyed on the input/output handshakes.
module tb_fpmul_norm_round;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [5:0]  in_exp_sum;
  logic [21:0] in_prod;
  logic        in_zero;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic        out_ovf;
  logic        out_unf;

  int checks = 0;
  int failures = 0;
  int outCount = 0;
  bit accepted = 1'b0;
  logic [17:0] sb[$];

  fpmul_norm_round dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_sign_i    (in_sign),
    .in_exp_sum_i (in_exp_sum),
    .in_prod_i    (in_prod),
    .in_zero_i    (in_zero),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_result_o (out_result),
    .out_ovf_o    (out_ovf),
    .out_unf_o    (out_unf)
  );

  always #5 clk = ~clk;

  // Integer reference: returns {ovf, unf, result}.
  function automatic logic [17:0] refModel(input logic s, input logic [5:0] es,
                                           input logic [21:0] p, input logic z);
    int e;
    int sig;
    int rem;
    int half;
    if (z) return {2'b00, s, 15'd0};
    if (p[21]) begin
      sig = int'(p >> 11); rem = int'(p & 22'h7FF); half = 'h400; e = int'(es) - 14;
    end else begin
      sig = int'(p >> 10); rem = int'(p & 22'h3FF); half = 'h200; e = int'(es) - 15;
    end
    if (rem > half || (rem == half && sig[0])) sig++;
    if (sig >= 'h800) begin
      sig = sig >> 1;
      e++;
    end
    if (e >= 31) return {2'b10, s, 5'h1F, 10'h0};
    if (e <= 0) return {2'b01, s, 15'd0};
    return {2'b00, s, e[4:0], sig[9:0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [5:0] es, input logic [21:0] p,
                               input logic z);
    in_valid   = 1'b1;
    in_sign    = s;
    in_exp_sum = es;
    in_prod    = p;
    in_zero    = z;
  endtask

  // Sample handshakes at the falling edge, then step past the rising edge.
  task automatic waitCycle();
    logic [17:0] e;
    @(negedge clk);
    accepted = 1'b0;
    if (rst_n && in_valid && in_ready) begin
      sb.push_back(refModel(in_sign, in_exp_sum, in_prod, in_zero));
      accepted = 1'b1;
    end
    if (rst_n && out_valid && out_ready) begin
      outCount++;
      checkOutput("sb_nonempty", 16'(sb.size() != 0), 16'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checkOutput("sb_result", out_result, e[15:0]);
        checkOutput("sb_ovf", 16'(out_ovf), 16'(e[17]));
        checkOutput("sb_unf", 16'(out_unf), 16'(e[16]));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic directedCase(input string tag, input logic s, input logic [5:0] es,
                              input logic [21:0] p, input logic z, input logic [15:0] expRes,
                              input logic expOvf, input logic expUnf);
    applyStimulus(s, es, p, z);
    waitCycle();
    checkOutput({tag, "_acc"}, 16'(accepted), 16'd1);
    in_valid = 1'b0;
    checkOutput({tag, "_v1"}, 16'(out_valid), 16'd0);
    waitCycle();
    checkOutput({tag, "_v2"}, 16'(out_valid), 16'd1);
    checkOutput({tag, "_res"}, out_result, expRes);
    checkOutput({tag, "_ovf"}, 16'(out_ovf), 16'(expOvf));
    checkOutput({tag, "_unf"}, 16'(out_unf), 16'(expUnf));
    waitCycle();
  endtask

  logic        bpS[4]  = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic [5:0]  bpE[4]  = '{6'd30, 6'd30, 6'd31, 6'd20};
  logic [21:0] bpP[4]  = '{22'h100000, 22'h240000, 22'h300000, 22'h1FFFFF};

  initial begin
    int k;
    int base;
    int sent;
    logic [15:0] held;
    logic [9:0] fa, fb;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_sign = 1'b0; in_exp_sum = '0; in_prod = '0; in_zero = 1'b0;
    held = '0;

    repeat (2) waitCycle();
    checkOutput("rst_out_valid", 16'(out_valid), 16'd0);
    checkOutput("rst_result", out_result, 16'h0000);
    checkOutput("rst_ovf", 16'(out_ovf), 16'd0);
    checkOutput("rst_unf", 16'(out_unf), 16'd0);
    rst_n = 1'b1;
    waitCycle();
    checkOutput("rst_in_ready", 16'(in_ready), 16'd1);

    directedCase("one",      1'b0, 6'd30, 22'h100000, 1'b0, 16'h3C00, 1'b0, 1'b0);
    directedCase("onefive",  1'b0, 6'd30, 22'h240000, 1'b0, 16'h4080, 1'b0, 1'b0);
    directedCase("rcarry",   1'b0, 6'd30, 22'h1FFFFF, 1'b0, 16'h4000, 1'b0, 1'b0);
    directedCase("rc_ovf",   1'b0, 6'd45, 22'h1FFFFF, 1'b0, 16'h7C00, 1'b1, 1'b0);
    directedCase("ovf_neg",  1'b1, 6'd60, 22'h100000, 1'b0, 16'hFC00, 1'b1, 1'b0);
    directedCase("unf",      1'b0, 6'd10, 22'h100000, 1'b0, 16'h0000, 1'b0, 1'b1);
    directedCase("zero",     1'b1, 6'd30, 22'h100000, 1'b1, 16'h8000, 1'b0, 1'b0);
    directedCase("es62",     1'b0, 6'd62, 22'h100000, 1'b0, 16'h7C00, 1'b1, 1'b0);
    directedCase("es0",      1'b0, 6'd0,  22'h100000, 1'b0, 16'h0000, 1'b0, 1'b1);
    directedCase("emax",     1'b0, 6'd45, 22'h100000, 1'b0, 16'h7800, 1'b0, 1'b0);
    directedCase("emin",     1'b0, 6'd16, 22'h100000, 1'b0, 16'h0400, 1'b0, 1'b0);
    directedCase("tie_even", 1'b0, 6'd30, 22'h100200, 1'b0, 16'h3C00, 1'b0, 1'b0);
    directedCase("tie_odd",  1'b0, 6'd30, 22'h100600, 1'b0, 16'h3C02, 1'b0, 1'b0);

    // Backpressure: four offered with the output stalled for four cycles.
    out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 4; c++) begin
      if (k < 4) applyStimulus(bpS[k], bpE[k], bpP[k], 1'b0);
      else in_valid = 1'b0;
      waitCycle();
      if (accepted) k++;
      if (c == 1) begin
        held = out_result;
        checkOutput("bp_first", held, 16'h3C00);
      end
      if (c >= 2) begin
        checkOutput("bp_hold", out_result, held);
        checkOutput("bp_hold_valid", 16'(out_valid), 16'd1);
      end
    end
    checkOutput("bp_accepted", 16'(k), 16'd2);
    checkOutput("bp_in_ready", 16'(in_ready), 16'd0);
    out_ready = 1'b1;
    base = outCount;
    for (int c = 0; c < 20; c++) begin
      if (k < 4) applyStimulus(bpS[k], bpE[k], bpP[k], 1'b0);
      else in_valid = 1'b0;
      waitCycle();
      if (accepted) k++;
      if (k == 4 && sb.size() == 0) break;
    end
    in_valid = 1'b0;
    checkOutput("bp_all_accepted", 16'(k), 16'd4);
    checkOutput("bp_out_count", 16'(outCount - base), 16'd4);
    checkOutput("bp_sb_empty", 16'(sb.size()), 16'd0);

    // Reset with both stages occupied.
    out_ready = 1'b0;
    applyStimulus(1'b0, 6'd30, 22'h100000, 1'b0);
    waitCycle();
    applyStimulus(1'b1, 6'd31, 22'h240000, 1'b0);
    waitCycle();
    applyStimulus(1'b0, 6'd33, 22'h300000, 1'b0);
    waitCycle();
    checkOutput("rf_full_valid", 16'(out_valid), 16'd1);
    checkOutput("rf_full_ready", 16'(in_ready), 16'd0);
    rst_n = 1'b0;
    in_valid = 1'b0;
    waitCycle();
    rst_n = 1'b1;
    checkOutput("rf_out_valid", 16'(out_valid), 16'd0);
    checkOutput("rf_in_ready", 16'(in_ready), 16'd1);
    sb.delete();
    out_ready = 1'b1;
    base = outCount;
    repeat (4) waitCycle();
    checkOutput("rf_no_ghost", 16'(outCount - base), 16'd0);

    // Random stream with random downstream stalls.
    base = outCount;
    sent = 0;
    for (int c = 0; c < 400; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (sent < 30) begin
        fa = 10'($urandom_range(0, 1023));
        fb = 10'($urandom_range(0, 1023));
        if (!in_valid || accepted)
          applyStimulus(1'($urandom_range(0, 1)), 6'($urandom_range(0, 62)),
                        22'({1'b1, fa}) * 22'({1'b1, fb}), ($urandom_range(0, 9) == 0));
      end else begin
        in_valid = 1'b0;
      end
      waitCycle();
      if (accepted) sent++;
      if (sent == 30 && sb.size() == 0) break;
    end
    in_valid = 1'b0;
    checkOutput("rnd_sent", 16'(sent), 16'd30);
    checkOutput("rnd_out_count", 16'(outCount - base), 16'd30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
